// File: rtl/decode_stage.sv
// decode_stage: registered decode pipeline stage for the 16-bit ISA.
// Takes one instruction per cycle over a valid/ready handshake, decodes the
// opcode into register fields, immediates and control bits, and holds the
// result in an output register for the execute stage.
// A load-use scoreboard stalls any instruction that touches the destination
// of a load that is still in flight.
// After a HALT is accepted, intake stops. Only rst or a flush (before the
// HALT leaves) resumes intake. Flush squashes the held instruction.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake, instr is the instruction word
//   flush               squash the held instruction
//   wb_valid/wb_rd      load writeback; clears the scoreboard bit, with bypass
//   out_valid/out_ready output handshake
//   out_rd/rs/rt, out_cond, out_imm, out_call, out_ctrl   decoded fields
//   halted              HALT has been transferred downstream
module decode_stage #(
  parameter int REG_AW   = 4,
  parameter int IMM_W    = 9,
  parameter int CALL_W   = 12,
  parameter int LINK_REG = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [2:0]        out_cond,
  output logic [IMM_W-1:0]  out_imm,
  output logic [CALL_W-1:0] out_call,
  output logic [7:0]        out_ctrl,
  output logic              halted
);

  localparam int NREG = 1 << REG_AW;

  logic [REG_AW-1:0] dec_rd_s, dec_rs_s, dec_rt_s;
  logic [2:0]        dec_cond_s;
  logic [IMM_W-1:0]  dec_imm_s;
  logic [CALL_W-1:0] dec_call_s;
  logic [7:0]        dec_ctrl_s;
  logic              reads_rs_s, reads_rt_s, writes_rd_s;
  logic [NREG-1:0]   pend_s;
  logic              hazard_s, accept_s, xfer_s;

  logic              out_valid_q, out_valid_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d, out_rs_q, out_rs_d, out_rt_q, out_rt_d;
  logic [2:0]        out_cond_q, out_cond_d;
  logic [IMM_W-1:0]  out_imm_q, out_imm_d;
  logic [CALL_W-1:0] out_call_q, out_call_d;
  logic [7:0]        out_ctrl_q, out_ctrl_d;
  logic [NREG-1:0]   sb_q, sb_d;
  logic              halt_seen_q, halt_seen_d;
  logic              halted_q, halted_d;

  // Opcode decode: any field not used by an opcode stays at zero.
  always_comb begin
    dec_rd_s   = '0;
    dec_rs_s   = '0;
    dec_rt_s   = '0;
    dec_cond_s = 3'b000;
    dec_imm_s  = '0;
    dec_call_s = '0;
    dec_ctrl_s = 8'h00;
    reads_rs_s = 1'b0;
    reads_rt_s = 1'b0;
    case (instr[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        dec_rd_s   = REG_AW'(instr[11:8]);
        dec_rs_s   = REG_AW'(instr[7:4]);
        dec_rt_s   = REG_AW'(instr[3:0]);
        dec_ctrl_s = 8'h01;
        reads_rs_s = 1'b1;
        reads_rt_s = 1'b1;
      end
      4'h8: begin
        dec_rd_s   = REG_AW'(instr[11:8]);
        dec_rs_s   = REG_AW'(instr[7:4]);
        dec_imm_s  = IMM_W'($signed(instr[3:0]));
        dec_ctrl_s = 8'h83;
        reads_rs_s = 1'b1;
      end
      4'h9: begin
        dec_rt_s   = REG_AW'(instr[11:8]);
        dec_rs_s   = REG_AW'(instr[7:4]);
        dec_imm_s  = IMM_W'($signed(instr[3:0]));
        dec_ctrl_s = 8'h84;
        reads_rs_s = 1'b1;
        reads_rt_s = 1'b1;
      end
      4'hA, 4'hB: begin
        // LHB/LLB modify one byte of rd, so rd is also a source.
        dec_rd_s   = REG_AW'(instr[11:8]);
        dec_rs_s   = REG_AW'(instr[11:8]);
        dec_imm_s  = IMM_W'(instr[7:0]);
        dec_ctrl_s = 8'h81;
        reads_rs_s = 1'b1;
      end
      4'hC: begin
        dec_cond_s = instr[11:9];
        dec_imm_s  = IMM_W'($signed(instr[8:0]));
        dec_ctrl_s = 8'hC0;
      end
      4'hD: begin
        dec_rd_s   = REG_AW'(LINK_REG);
        dec_call_s = CALL_W'(instr[11:0]);
        dec_ctrl_s = 8'h11;
      end
      4'hE: begin
        dec_rs_s   = REG_AW'(instr[7:4]);
        dec_ctrl_s = 8'h20;
        reads_rs_s = 1'b1;
      end
      4'hF: begin
        dec_ctrl_s = 8'h08;
      end
      default: begin
        dec_ctrl_s = 8'h00;
      end
    endcase
    writes_rd_s = dec_ctrl_s[0];
  end

  // Per-register pending: a load is in flight, or a load is in the output
  // register. A writeback in this cycle bypasses the pending state.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pend_s[i] = (sb_q[i] | (out_valid_q & out_ctrl_q[1] & (out_rd_q == REG_AW'(i))))
                & ~(wb_valid & (wb_rd == REG_AW'(i)));
    end
  end

  assign hazard_s = in_valid & ((reads_rs_s & pend_s[dec_rs_s]) |
                                (reads_rt_s & pend_s[dec_rt_s]) |
                                (writes_rd_s & pend_s[dec_rd_s]));
  assign in_ready = ~rst & ~flush & ~halt_seen_q & ~hazard_s & (~out_valid_q | out_ready);
  assign accept_s = in_valid & in_ready;
  // A flush overrides out_ready, so the squashed instruction never leaves.
  assign xfer_s   = out_valid_q & out_ready & ~flush;

  // Next-state for the output register, the scoreboard and the halt flags.
  always_comb begin
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_rs_d    = out_rs_q;
    out_rt_d    = out_rt_q;
    out_cond_d  = out_cond_q;
    out_imm_d   = out_imm_q;
    out_call_d  = out_call_q;
    out_ctrl_d  = out_ctrl_q;
    sb_d        = sb_q;
    halt_seen_d = halt_seen_q;
    halted_d    = halted_q;

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_rd_d    = dec_rd_s;
      out_rs_d    = dec_rs_s;
      out_rt_d    = dec_rt_s;
      out_cond_d  = dec_cond_s;
      out_imm_d   = dec_imm_s;
      out_call_d  = dec_call_s;
      out_ctrl_d  = dec_ctrl_s;
    end else if (out_valid_q & (out_ready | flush)) begin
      out_valid_d = 1'b0;
      out_rd_d    = '0;
      out_rs_d    = '0;
      out_rt_d    = '0;
      out_cond_d  = 3'b000;
      out_imm_d   = '0;
      out_call_d  = '0;
      out_ctrl_d  = 8'h00;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Clear before set, so a set wins on the same bit.
    if (wb_valid) begin
      sb_d[wb_rd] = 1'b0;
    end else begin
      sb_d = sb_q;
    end
    if (xfer_s & out_ctrl_q[1]) begin
      sb_d[out_rd_q] = 1'b1;
    end else begin
      sb_d = sb_d;
    end

    if (accept_s & dec_ctrl_s[3]) begin
      halt_seen_d = 1'b1;
    end else if (flush & ~halted_q) begin
      halt_seen_d = 1'b0;
    end else begin
      halt_seen_d = halt_seen_q;
    end

    if (xfer_s & out_ctrl_q[3]) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_rs_q    <= '0;
      out_rt_q    <= '0;
      out_cond_q  <= 3'b000;
      out_imm_q   <= '0;
      out_call_q  <= '0;
      out_ctrl_q  <= 8'h00;
      sb_q        <= {NREG{1'b0}};
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_rs_q    <= out_rs_d;
      out_rt_q    <= out_rt_d;
      out_cond_q  <= out_cond_d;
      out_imm_q   <= out_imm_d;
      out_call_q  <= out_call_d;
      out_ctrl_q  <= out_ctrl_d;
      sb_q        <= sb_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_rs    = out_rs_q;
  assign out_rt    = out_rt_q;
  assign out_cond  = out_cond_q;
  assign out_imm   = out_imm_q;
  assign out_call  = out_call_q;
  assign out_ctrl  = out_ctrl_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed test-plan sequences, then randomized
// traffic checked against a behavioural model with an expected-output queue.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = 16'h0000;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_rd = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_rd, out_rs, out_rt;
  logic [2:0]  out_cond;
  logic [8:0]  out_imm;
  logic [11:0] out_call;
  logic [7:0]  out_ctrl;
  logic        halted;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_cond(out_cond), .out_imm(out_imm), .out_call(out_call), .out_ctrl(out_ctrl),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rd, rs, rt;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [11:0] call;
    logic [7:0]  ctrl;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  exp_t expq[$];

  // Behavioural model state.
  logic [15:0] busy = 16'h0000;   // loads transferred, writeback outstanding
  bit          m_held = 1'b0, m_held_lw = 1'b0, m_held_halt = 1'b0;
  logic [3:0]  m_held_rd = 4'h0;
  bit          m_halt_seen = 1'b0, m_halted = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t decode_ref(input logic [15:0] w);
    exp_t e;
    int   op, v;
    e  = '0;
    op = int'(w[15:12]);
    v  = int'(w[3:0]);
    if (v >= 8) v = v - 16;
    if (op <= 7) begin
      e.rd = w[11:8]; e.rs = w[7:4]; e.rt = w[3:0]; e.ctrl = 8'h01;
    end else if (op == 8) begin
      e.rd = w[11:8]; e.rs = w[7:4]; e.imm = 9'(v); e.ctrl = 8'h83;
    end else if (op == 9) begin
      e.rt = w[11:8]; e.rs = w[7:4]; e.imm = 9'(v); e.ctrl = 8'h84;
    end else if (op == 10 || op == 11) begin
      e.rd = w[11:8]; e.rs = w[11:8]; e.imm = {1'b0, w[7:0]}; e.ctrl = 8'h81;
    end else if (op == 12) begin
      e.cond = w[11:9]; e.imm = w[8:0]; e.ctrl = 8'hC0;
    end else if (op == 13) begin
      e.rd = 4'd15; e.call = w[11:0]; e.ctrl = 8'h11;
    end else if (op == 14) begin
      e.rs = w[7:4]; e.ctrl = 8'h20;
    end else begin
      e.ctrl = 8'h08;
    end
    return e;
  endfunction

  function automatic void usage(input logic [15:0] w, output bit r_rs, output bit r_rt, output bit wr);
    int op;
    op   = int'(w[15:12]);
    r_rs = (op <= 11) || (op == 14);
    r_rt = (op <= 7) || (op == 9);
    wr   = (op <= 8) || (op == 10) || (op == 11) || (op == 13);
  endfunction

  function automatic bit pending(input logic [3:0] r);
    return (busy[r] || (m_held && m_held_lw && m_held_rd == r)) && !(wb_valid && wb_rd == r);
  endfunction

  function automatic bit exp_ready();
    exp_t d;
    bit   r_rs, r_rt, wr;
    if (rst || flush || m_halt_seen) return 1'b0;
    if (m_held && !out_ready) return 1'b0;
    if (!in_valid) return 1'b1;
    d = decode_ref(instr);
    usage(instr, r_rs, r_rt, wr);
    return !((r_rs && pending(d.rs)) || (r_rt && pending(d.rt)) || (wr && pending(d.rd)));
  endfunction

  // Predictor: advances the model on each clock edge, pushes accepted decodes.
  always @(posedge clk) begin
    exp_t d;
    bit   acc, xf;
    if (rst) begin
      busy        <= 16'h0000;
      m_held      <= 1'b0;
      m_held_lw   <= 1'b0;
      m_held_halt <= 1'b0;
      m_held_rd   <= 4'h0;
      m_halt_seen <= 1'b0;
      m_halted    <= 1'b0;
    end else begin
      acc = in_valid && exp_ready();
      xf  = m_held && out_ready && !flush;
      if (wb_valid) busy[wb_rd] <= 1'b0;
      if (xf && m_held_lw) busy[m_held_rd] <= 1'b1;
      if (xf && m_held_halt) m_halted <= 1'b1;
      if (flush && !m_halted) m_halt_seen <= 1'b0;
      if (acc) begin
        d = decode_ref(instr);
        expq.push_back(d);
        m_held      <= 1'b1;
        m_held_lw   <= (instr[15:12] == 4'h8);
        m_held_halt <= (instr[15:12] == 4'hF);
        m_held_rd   <= d.rd;
        if (instr[15:12] == 4'hF) m_halt_seen <= 1'b1;
      end else if (m_held && (out_ready || flush)) begin
        m_held <= 1'b0;
      end
    end
  end

  // Monitor: compares handshake and held output against the model each cycle.
  always @(negedge clk) begin
    exp_t got, e;
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_held));
      chk("halted", 64'(halted), 64'(m_halted));
      if (out_valid && expq.size() > 0) begin
        got = {out_rd, out_rs, out_rt, out_cond, out_imm, out_call, out_ctrl};
        if (rst || flush) begin
          e = expq.pop_front();
          chk("held_fields", 64'(got), 64'(e));
        end else if (out_ready) begin
          e = expq.pop_front();
          chk("xfer_fields", 64'(got), 64'(e));
        end else begin
          e = expq[0];
          chk("stall_fields", 64'(got), 64'(e));
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [15:0] w, input bit ordy,
                     input bit fl, input bit wbv, input logic [3:0] wbr);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; instr = w; out_ready = ordy; flush = fl;
    wb_valid = wbv; wb_rd = wbr;
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  r;
    int          op;

    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 16'h0312, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("rst_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({out_rd, out_rs, out_rt, out_cond, out_imm, out_call, out_ctrl}), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);

    // Back-to-back ALU
    cyc(1'b0, 1'b1, 16'h0312, 1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 16'h1423, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("alu0", 64'({out_rd, out_rs, out_rt, out_ctrl}), 64'h312_01);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("alu1", 64'({out_rd, out_rs, out_rt, out_ctrl}), 64'h423_01);

    // Load-use
    cyc(1'b0, 1'b1, 16'h841F, 1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 16'h0541, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("lw_fields", 64'({out_rd, out_rs, out_imm, out_ctrl}), {40'd0, 4'h4, 4'h1, 9'h1FF, 8'h83});
    chk("lu_stall0", 64'(in_ready), 64'd0);
    cyc(1'b0, 1'b1, 16'h0541, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("lu_stall1", 64'(in_ready), 64'd0);
    cyc(1'b0, 1'b1, 16'h0541, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("lu_stall2", 64'(in_ready), 64'd0);
    cyc(1'b0, 1'b1, 16'h0541, 1'b1, 1'b0, 1'b1, 4'h4);
    #2 chk("lu_bypass", 64'(in_ready), 64'd1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("lu_add", 64'({out_rd, out_rs, out_rt}), 64'h541);

    // Backpressure on SW
    cyc(1'b0, 1'b1, 16'h9215, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'h0312, 1'b0, 1'b0, 1'b0, 4'h0);
      #2 chk("bp_fields", 64'({out_rt, out_rs, out_imm, out_ctrl}), {39'd0, 4'h2, 4'h1, 9'h005, 8'h84});
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);

    // CALL and B
    cyc(1'b0, 1'b1, 16'hD123, 1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 16'hC9F0, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("call", 64'({out_rd, out_call, out_ctrl}), 64'hF_123_11);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("branch", 64'({out_cond, out_imm, out_ctrl, out_rd, out_rs, out_rt}), {32'd0, 3'd4, 9'h1F0, 8'hC0, 12'h000});

    // HALT then transfer
    cyc(1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 16'h0312, 1'b0, 1'b0, 1'b0, 4'h0);
    #2 chk("halt_block0", 64'(in_ready), 64'd0);
    cyc(1'b0, 1'b1, 16'h0312, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("halt_block1", 64'(in_ready), 64'd0);
    cyc(1'b0, 1'b1, 16'h0312, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("halted_set", 64'(halted), 64'd1);
    chk("halt_block2", 64'(in_ready), 64'd0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("halted_rst", 64'(halted), 64'd0);

    // HALT squashed by flush
    cyc(1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 16'h0312, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("halt_flush_ready", 64'(in_ready), 64'd1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("halt_flush_next", 64'({halted, out_rd}), 64'h03);

    // Flush of a held LW
    cyc(1'b0, 1'b1, 16'h8412, 1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 16'h0541, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("flush_lw_nostall", 64'(in_ready), 64'd1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    #2 chk("flush_lw_next", 64'(out_rd), 64'd5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      w  = 16'($urandom);
      op = $urandom_range(0, 14);
      if ($urandom_range(0, 99) == 0) op = 15;
      w[15:12] = 4'(op);
      if ($urandom_range(0, 1) == 1) begin
        w[11] = 1'b0; w[7] = 1'b0; w[3] = 1'b0;
      end
      r = 4'($urandom_range(0, 15));
      if (busy != 16'h0000 && $urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin
          if (busy[(int'(r) + k) % 16]) begin
            r = 4'((int'(r) + k) % 16);
            break;
          end
        end
      end
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, w,
          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 30, r);
    end
    for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
